// File: rtl/mul_float_pipe.sv
// rtl/mul_float_pipe.sv - three-stage pipelined floating-point multiplier with valid/ready flow control
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready/op1/op2/in_tag    operand channel
//        out_valid/out_ready/out/out_tag     result channel
//        nan/overflow/underflow/zero/inexact result flags, aligned with out
module mul_float_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] op1,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] op2,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] out,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic                          nan,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          zero,
    output logic                          inexact
);
    localparam int E  = EXP_WIDTH;
    localparam int F  = FRAC_WIDTH;
    localparam int W  = 1 + E + F;
    localparam int EW = E + 2;          // two guard bits; MSB is the sign of the exponent
    localparam int PW = 2 * F + 2;
    localparam logic [EW-1:0] BIAS = EW'((1 << (E - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << E) - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F - 1){1'b0}}};

    // Whole pipeline freezes while the output register holds an unaccepted result.
    logic w_adv;
    assign w_adv    = ~(out_valid & ~out_ready);
    assign in_ready = w_adv;

    // Stage 1: unpack and classify
    logic [E-1:0]  w_ea, w_eb;
    logic [F-1:0]  w_fa, w_fb;
    logic          w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic          w_s1_nan, w_s1_inf, w_s1_zero;
    logic [EW-1:0] w_esum;

    assign w_ea     = op1[F +: E];
    assign w_eb     = op2[F +: E];
    assign w_fa     = op1[F-1:0];
    assign w_fb     = op2[F-1:0];
    // exp == 0 covers both true zero and subnormals (flushed to zero)
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) & ~(|w_fa);
    assign w_b_inf  = (&w_eb) & ~(|w_fb);
    assign w_a_nan  = (&w_ea) & (|w_fa);
    assign w_b_nan  = (&w_eb) & (|w_fb);
    assign w_s1_nan = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_s1_inf = ~w_s1_nan & (w_a_inf | w_b_inf);
    assign w_s1_zero = ~w_s1_nan & ~w_s1_inf & (w_a_zero | w_b_zero);
    assign w_esum   = EW'(w_ea) + EW'(w_eb) - BIAS;

    logic                 r1_valid, r1_sign, r1_nan, r1_inf, r1_zero;
    logic [EW-1:0]        r1_exp;
    logic [F:0]           r1_ma, r1_mb;
    logic [TAG_WIDTH-1:0] r1_tag;

    logic                 r2_valid, r2_sign, r2_nan, r2_inf, r2_zero;
    logic [EW-1:0]        r2_exp;
    logic [PW-1:0]        r2_prod;
    logic [TAG_WIDTH-1:0] r2_tag;

    logic                 r3_valid;
    logic [W-1:0]         r_out;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_nan, r_ovf, r_unf, r_zero, r_inex;

    // Stage 3: normalise, round, pack
    logic          w_top, w_guard, w_sticky, w_round, w_ovf, w_unf;
    logic [PW-1:0] w_norm;
    logic [F-1:0]  w_frac;
    logic [F:0]    w_frac_rnd;
    logic [EW-1:0] w_exp_fin;

    // Shift so the leading one always sits at the product MSB.
    assign w_top      = r2_prod[PW-1];
    assign w_norm     = w_top ? r2_prod : {r2_prod[PW-2:0], 1'b0};
    assign w_frac     = w_norm[PW-2 -: F];
    assign w_guard    = w_norm[F];
    assign w_sticky   = |w_norm[F-1:0];
    assign w_round    = w_guard & (w_sticky | w_frac[0]);
    // A carry out leaves the fraction field all zero, so only the exponent needs bumping.
    assign w_frac_rnd = {1'b0, w_frac} + {{F{1'b0}}, w_round};
    assign w_exp_fin  = r2_exp + EW'(w_top) + EW'(w_frac_rnd[F]);
    assign w_ovf      = ~w_exp_fin[EW-1] & (w_exp_fin >= EMAX);
    assign w_unf      = w_exp_fin[EW-1] | (w_exp_fin == '0);

    logic [W-1:0] w_res;
    logic         w_f_nan, w_f_ovf, w_f_unf, w_f_zero, w_f_inex;

    always_comb begin
        w_res    = {r2_sign, w_exp_fin[E-1:0], w_frac_rnd[F-1:0]};
        w_f_nan  = 1'b0;
        w_f_ovf  = 1'b0;
        w_f_unf  = 1'b0;
        w_f_zero = 1'b0;
        w_f_inex = w_guard | w_sticky;
        if (r2_nan) begin
            w_res    = QNAN;
            w_f_nan  = 1'b1;
            w_f_inex = 1'b0;
        end else if (r2_inf) begin
            w_res    = {r2_sign, {E{1'b1}}, {F{1'b0}}};
            w_f_inex = 1'b0;
        end else if (r2_zero) begin
            w_res    = {r2_sign, {(E + F){1'b0}}};
            w_f_zero = 1'b1;
            w_f_inex = 1'b0;
        end else if (w_ovf) begin
            w_res    = {r2_sign, {E{1'b1}}, {F{1'b0}}};
            w_f_ovf  = 1'b1;
            w_f_inex = 1'b1;
        end else if (w_unf) begin
            w_res    = {r2_sign, {(E + F){1'b0}}};
            w_f_unf  = 1'b1;
            w_f_zero = 1'b1;
            w_f_inex = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0; r1_sign <= 1'b0; r1_nan <= 1'b0; r1_inf <= 1'b0; r1_zero <= 1'b0;
            r1_exp   <= '0;   r1_ma   <= '0;   r1_mb  <= '0;   r1_tag <= '0;
            r2_valid <= 1'b0; r2_sign <= 1'b0; r2_nan <= 1'b0; r2_inf <= 1'b0; r2_zero <= 1'b0;
            r2_exp   <= '0;   r2_prod <= '0;   r2_tag <= '0;
            r3_valid <= 1'b0; r_out   <= '0;   r_tag  <= '0;
            r_nan    <= 1'b0; r_ovf   <= 1'b0; r_unf  <= 1'b0; r_zero <= 1'b0; r_inex <= 1'b0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_sign  <= op1[W-1] ^ op2[W-1];
            r1_nan   <= w_s1_nan;
            r1_inf   <= w_s1_inf;
            r1_zero  <= w_s1_zero;
            r1_exp   <= w_esum;
            r1_ma    <= {1'b1, w_fa};
            r1_mb    <= {1'b1, w_fb};
            r1_tag   <= in_tag;

            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_nan   <= r1_nan;
            r2_inf   <= r1_inf;
            r2_zero  <= r1_zero;
            r2_exp   <= r1_exp;
            r2_prod  <= PW'(r1_ma) * PW'(r1_mb);
            r2_tag   <= r1_tag;

            r3_valid <= r2_valid;
            r_out    <= w_res;
            r_tag    <= r2_tag;
            r_nan    <= w_f_nan;
            r_ovf    <= w_f_ovf;
            r_unf    <= w_f_unf;
            r_zero   <= w_f_zero;
            r_inex   <= w_f_inex;
        end
    end

    assign out_valid = r3_valid;
    assign out       = r_out;
    assign out_tag   = r_tag;
    assign nan       = r_nan;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign zero      = r_zero;
    assign inexact   = r_inex;
endmodule

// File: tb/tb_mul_float_pipe.sv
// tb/tb_mul_float_pipe.sv - self-checking bench for mul_float_pipe (single and half precision)
module tb_mul_float_pipe;
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op1, op2, out;
    logic [3:0]  in_tag, out_tag;
    logic        nan, overflow, underflow, zero, inexact;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_op1, h_op2, h_out;
    logic [3:0]  h_in_tag, h_out_tag;
    logic        h_nan, h_overflow, h_underflow, h_zero, h_inexact;

    mul_float_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag),
        .nan(nan), .overflow(overflow), .underflow(underflow), .zero(zero), .inexact(inexact)
    );

    mul_float_pipe #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .TAG_WIDTH(4)) u_half (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op1(h_op1), .op2(h_op2), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out(h_out), .out_tag(h_out_tag),
        .nan(h_nan), .overflow(h_overflow), .underflow(h_underflow), .zero(h_zero), .inexact(h_inexact)
    );

    int checks = 0;
    int errors = 0;
    int n_rx = 0;
    int stall_cnt = 0;
    logic [40:0] sb_q[$];   // {tag, nan, ovf, unf, zero, inexact, out}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: value-level multiply with integer division for rounding.
    // Returns {nan, overflow, underflow, zero, inexact, result}.
    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int ew, input int fw);
        longint one, emax, bias, ea, eb, fa, fb, sgn, prod, dv, q, r, e, res;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        one  = 1;
        emax = (one << ew) - 1;
        bias = (one << (ew - 1)) - 1;
        ea   = longint'(a >> fw) & emax;
        eb   = longint'(b >> fw) & emax;
        fa   = longint'(a) & ((one << fw) - 1);
        fb   = longint'(b) & ((one << fw) - 1);
        sgn  = longint'((a ^ b) >> (ew + fw)) & 1;
        a_nan = (ea == emax) && (fa != 0);  b_nan = (eb == emax) && (fb != 0);
        a_inf = (ea == emax) && (fa == 0);  b_inf = (eb == emax) && (fb == 0);
        a_zero = (ea == 0);                 b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = (emax << fw) | (one << (fw - 1));
            return {5'b10000, 32'(res)};
        end
        if (a_inf || b_inf) begin
            res = (sgn << (ew + fw)) | (emax << fw);
            return {5'b00000, 32'(res)};
        end
        if (a_zero || b_zero) begin
            res = sgn << (ew + fw);
            return {5'b00010, 32'(res)};
        end
        prod = ((one << fw) + fa) * ((one << fw) + fb);
        e  = ea + eb - bias;
        dv = one << fw;
        if (prod >= (one << (2 * fw + 1))) begin
            dv = dv * 2;
            e  = e + 1;
        end
        q = prod / dv;
        r = prod % dv;
        if ((2 * r > dv) || ((2 * r == dv) && (q % 2 == 1))) q = q + 1;
        if (q == (one << (fw + 1))) begin
            q = q / 2;
            e = e + 1;
        end
        if (e >= emax) begin
            res = (sgn << (ew + fw)) | (emax << fw);
            return {5'b01001, 32'(res)};
        end
        if (e <= 0) begin
            res = sgn << (ew + fw);
            return {5'b00111, 32'(res)};
        end
        res = (sgn << (ew + fw)) | (e << fw) | (q - (one << fw));
        return {4'b0000, (r != 0), 32'(res)};
    endfunction

    function automatic logic [31:0] rand_op(input int ew, input int fw);
        int unsigned emax, bias, e, f, s;
        emax = (1 << ew) - 1;
        bias = (1 << (ew - 1)) - 1;
        case ($urandom_range(0, 9))
            0:       e = 0;
            1:       e = emax;
            2, 3:    e = $urandom_range(1, emax - 1);
            default: e = $urandom_range(bias - bias / 2, bias + bias / 2);
        endcase
        case ($urandom_range(0, 5))
            0:       f = 0;
            1:       f = (1 << fw) - 1;
            default: f = $urandom & ((1 << fw) - 1);
        endcase
        s = $urandom_range(0, 1);
        return 32'((s << (ew + fw)) | (e << fw) | f);
    endfunction

    // One clock of the single-precision channel; called just after a rising edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input logic rdy, output logic acc);
        in_valid = v; op1 = a; op2 = b; in_tag = t; out_ready = rdy;
        #1;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                check("result", {out_tag, nan, overflow, underflow, zero, inexact, out}, sb_q[0]);
                if (!out_ready) begin
                    stall_cnt++;
                    check("stall_in_ready", in_ready, 0);
                end else begin
                    void'(sb_q.pop_front());
                    n_rx++;
                end
            end
        end
        acc = v && in_ready;
        if (acc) sb_q.push_back({t, model(a, b, 8, 23)});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) cycle(0, 0, 0, 0, 1, acc);
        in_valid = 0;
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] t, input logic [31:0] eo, input logic [4:0] ef);
        in_valid = 1; op1 = a; op2 = b; in_tag = t; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        check({name, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        check({name, "_lat2"}, out_valid, 0);
        @(posedge clk); #1;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_out"}, out, eo);
        check({name, "_tag"}, out_tag, t);
        check({name, "_flags"}, {nan, overflow, underflow, zero, inexact}, ef);
    endtask

    task automatic h_dir(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eo, input logic [4:0] ef);
        h_in_valid = 1; h_op1 = a; h_op2 = b; h_in_tag = 4'd5;
        @(posedge clk); #1;
        h_in_valid = 0;
        @(posedge clk); #1;
        check({name, "_lat2"}, h_out_valid, 0);
        @(posedge clk); #1;
        check({name, "_valid"}, h_out_valid, 1);
        check({name, "_out"}, h_out, eo);
        check({name, "_flags"}, {h_nan, h_overflow, h_underflow, h_zero, h_inexact}, ef);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        acc;
        logic [31:0] sa[8], sb[8], a, b;
        logic [36:0] hm;
        int          idx, k, n0;

        rst = 1; in_valid = 0; op1 = 0; op2 = 0; in_tag = 0; out_ready = 1;
        h_in_valid = 0; h_op1 = 0; h_op2 = 0; h_in_tag = 0; h_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_flags", {nan, overflow, underflow, zero, inexact}, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 0;
        @(posedge clk); #1;

        directed("mul5x5",   32'h40A00000, 32'h40A00000, 4'd3, 32'h41C80000, 5'b00000);
        directed("neg5x5",   32'hC0A00000, 32'h40A00000, 4'd1, 32'hC1C80000, 5'b00000);
        directed("infx0",    32'h7F800000, 32'h00000000, 4'd2, 32'h7FC00000, 5'b10000);
        directed("ninfx2",   32'hFF800000, 32'h40000000, 4'd4, 32'hFF800000, 5'b00000);
        directed("subn",     32'h00400000, 32'h40000000, 4'd5, 32'h00000000, 5'b00010);
        directed("ovf",      32'h7F000000, 32'h7F000000, 4'd6, 32'h7F800000, 5'b01001);
        directed("unf",      32'h00800000, 32'h00800000, 4'd7, 32'h00000000, 5'b00111);
        directed("rnd_lsb",  32'h3F800001, 32'h3F800001, 4'd8, 32'h3F800002, 5'b00001);
        directed("rnd_max",  32'h3FFFFFFF, 32'h3FFFFFFF, 4'd9, 32'h407FFFFE, 5'b00001);

        h_dir("h_5x5", 16'h4500, 16'h4500, 16'h4E40, 5'b00000);
        h_dir("h_ovf", 16'h7BFF, 16'h4000, 16'h7C00, 5'b01001);
        for (int i = 0; i < 20; i++) begin
            a  = rand_op(5, 10);
            b  = rand_op(5, 10);
            hm = model(a, b, 5, 10);
            h_dir("h_rand", a[15:0], b[15:0], hm[15:0], hm[36:32]);
        end

        // Back-to-back stream with the consumer stalled for cycles 4..8.
        for (int i = 0; i < 8; i++) begin
            sa[i] = rand_op(8, 23);
            sb[i] = rand_op(8, 23);
        end
        n0 = n_rx; stall_cnt = 0; idx = 0; k = 0;
        while ((idx < 8 || sb_q.size() != 0) && k < 60) begin
            if (idx < 8) cycle(1, sa[idx], sb[idx], 4'(idx), !(k >= 4 && k <= 8), acc);
            else         cycle(0, 0, 0, 0, 1, acc);
            if (acc) idx++;
            k++;
        end
        check("stream_timeout", (k < 60), 1);
        check("stream_count", n_rx - n0, 8);
        check("stream_stalls", stall_cnt, 5);

        // Random traffic with random bubbles and backpressure.
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, rand_op(8, 23), rand_op(8, 23), 4'($urandom),
                  ($urandom % 4) != 0, acc);
        drain();

        // Reset with operations in flight.
        cycle(1, 32'h40A00000, 32'h40A00000, 4'd1, 0, acc);
        cycle(1, 32'h3F800001, 32'h3F800001, 4'd2, 0, acc);
        cycle(0, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, acc);
        check("pre_rst_valid", out_valid, 1);
        rst = 1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_out", out, 0);
        check("async_rst_tag", out_tag, 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, acc);
        check("post_rst_idle", out_valid, 0);
        directed("post_rst", 32'h40A00000, 32'h40A00000, 4'd3, 32'h41C80000, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
